dram_request_arbiter: RTL and testbench

Round-robin front end that sits directly upstream of the DRAM model on the memory bus. It collects read/write requests from NUM_SOURCES requesters (core load/store units, fetch), serialises them into single bus packets for DRAM, and keeps one transaction outstanding at a time. Read responses return from DRAM tagged with the packet source and are steered back to the originating requester. Out-of-range addresses are filtered before they can reach DRAM.

---
 rtl/dram_request_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dram_request_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_request_arbiter.sv
// Round-robin DRAM front end: one packet in flight, tagged read
// responses steered back to the requester, bad addresses filtered.
module dram_request_arbiter #(
  parameter int          NUM_SOURCES = 4,
  parameter int          SRC_W       = 3,
  parameter logic [63:0] MEM_BYTES   = 64'd65536
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SOURCES-1:0]   req_valid,
  output logic [NUM_SOURCES-1:0]   req_ready,
  input  logic [NUM_SOURCES-1:0]   req_is_read,
  input  logic [NUM_SOURCES*64-1:0] req_addr,
  input  logic [NUM_SOURCES*64-1:0] req_data,
  output logic [NUM_SOURCES-1:0]   rsp_valid,
  output logic [63:0]              rsp_data,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_is_read,
  output logic [63:0]              mem_req_addr,
  output logic [63:0]              mem_req_data,
  output logic [SRC_W-1:0]         mem_req_source,
  input  logic                     mem_rsp_valid,
  input  logic [63:0]              mem_rsp_data,
  input  logic [SRC_W-1:0]         mem_rsp_source,
  output logic                     err_addr,
  output logic                     err_source
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RSP,
    S_ERR_RSP
  } state_t;

  state_t                 r_state;
  logic [SRC_W-1:0]       r_rr_ptr;
  logic [NUM_SOURCES-1:0] r_rsp_valid;
  logic [63:0]            r_rsp_data;
  logic                   r_mem_req_valid;
  logic                   r_mem_req_is_read;
  logic [63:0]            r_mem_req_addr;
  logic [63:0]            r_mem_req_data;
  logic [SRC_W-1:0]       r_mem_req_source;
  logic                   r_err_addr;
  logic                   r_err_source;

  logic                   w_any;
  logic [SRC_W-1:0]       w_win;
  logic [SRC_W-1:0]       w_next_ptr;
  logic                   w_is_read;
  logic [63:0]            w_addr;
  logic [63:0]            w_data;
  logic                   w_legal;
  logic                   w_grant;
  int                     w_ptr;
  int                     w_d;
  int                     w_best;

  // Smallest rotational distance from rr_ptr wins.
  always_comb begin
    w_any     = 1'b0;
    w_win     = '0;
    w_is_read = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    w_ptr     = int'(r_rr_ptr);
    w_d       = 0;
    w_best    = NUM_SOURCES;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      w_d = (i >= w_ptr) ? i - w_ptr : i + NUM_SOURCES - w_ptr;
      if (req_valid[i] && w_d < w_best) begin
        w_best    = w_d;
        w_any     = 1'b1;
        w_win     = SRC_W'(i);
        w_is_read = req_is_read[i];
        w_addr    = req_addr[64*i +: 64];
        w_data    = req_data[64*i +: 64];
      end
    end
  end

  assign w_next_ptr = (w_win == SRC_W'(NUM_SOURCES - 1)) ?
                      '0 : w_win + SRC_W'(1);
  assign w_legal    = (w_addr <= MEM_BYTES - 64'd8);

  // Hold off a grant while a response pulse is out.
  assign w_grant = (r_state == S_IDLE) && w_any && !reset &&
                   !(|r_rsp_valid);

  assign req_ready = w_grant ?
                     (NUM_SOURCES'(1) << w_win) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_rr_ptr          <= '0;
      r_rsp_valid       <= '0;
      r_rsp_data        <= '0;
      r_mem_req_valid   <= 1'b0;
      r_mem_req_is_read <= 1'b0;
      r_mem_req_addr    <= '0;
      r_mem_req_data    <= '0;
      r_mem_req_source  <= '0;
      r_err_addr        <= 1'b0;
      r_err_source      <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (mem_rsp_valid && r_state != S_WAIT_RSP)
        r_err_source <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_mem_req_is_read <= w_is_read;
            r_mem_req_addr    <= w_addr;
            r_mem_req_data    <= w_data;
            r_mem_req_source  <= w_win;
            r_rr_ptr          <= w_next_ptr;
            if (w_legal) begin
              r_mem_req_valid <= 1'b1;
              r_state         <= S_ISSUE;
            end else begin
              r_err_addr <= 1'b1;
              if (w_is_read) begin
                r_rsp_valid <= NUM_SOURCES'(1) << w_win;
                r_rsp_data  <= '0;
                r_state     <= S_ERR_RSP;
              end
            end
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state <= r_mem_req_is_read ? S_WAIT_RSP : S_IDLE;
          end
        end
        S_WAIT_RSP: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_source == r_mem_req_source) begin
              r_rsp_data  <= mem_rsp_data;
              r_rsp_valid <= NUM_SOURCES'(1) << r_mem_req_source;
              r_state     <= S_IDLE;
            end else begin
              r_err_source <= 1'b1;
            end
          end
        end
        S_ERR_RSP: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign mem_req_valid   = r_mem_req_valid;
  assign mem_req_is_read = r_mem_req_is_read;
  assign mem_req_addr    = r_mem_req_addr;
  assign mem_req_data    = r_mem_req_data;
  assign mem_req_source  = r_mem_req_source;
  assign err_addr        = r_err_addr;
  assign err_source      = r_err_source;

endmodule

// File: tb/tb_dram_request_arbiter.sv
// Directed bench for dram_request_arbiter: write, read, OOR,
// fairness, backpressure, bad tag and reset.
module tb_dram_request_arbiter;

  localparam int NS = 4;
  localparam int SW = 3;

  logic            clk;
  logic            reset;
  logic [NS-1:0]   req_valid;
  logic [NS-1:0]   req_ready;
  logic [NS-1:0]   req_is_read;
  logic [NS*64-1:0] req_addr;
  logic [NS*64-1:0] req_data;
  logic [NS-1:0]   rsp_valid;
  logic [63:0]     rsp_data;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_is_read;
  logic [63:0]     mem_req_addr;
  logic [63:0]     mem_req_data;
  logic [SW-1:0]   mem_req_source;
  logic            mem_rsp_valid;
  logic [63:0]     mem_rsp_data;
  logic [SW-1:0]   mem_rsp_source;
  logic            err_addr;
  logic            err_source;

  int n_pass;
  int n_total;

  localparam logic [63:0] D1 = 64'h1122334455667788;

  dram_request_arbiter #(
    .NUM_SOURCES(NS),
    .SRC_W(SW),
    .MEM_BYTES(64'd65536)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_is_read(req_is_read),
    .req_addr(req_addr),
    .req_data(req_data),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_is_read(mem_req_is_read),
    .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_req_source(mem_req_source),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .mem_rsp_source(mem_rsp_source),
    .err_addr(err_addr),
    .err_source(err_source)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic set_src(input int s, input logic rd,
                         input logic [63:0] a,
                         input logic [63:0] d);
    req_is_read[s]     = rd;
    req_addr[64*s +: 64] = a;
    req_data[64*s +: 64] = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 4'b0001;
    nxt;
    nxt;
    #1;
    n_total++;
    if (req_ready !== 4'b0000)
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    else n_pass++;
    n_total++;
    if ({rsp_valid, mem_req_valid, err_addr, err_source}
        !== 7'b0)
      $display("FAIL reset_outs: got %b want 0",
               {rsp_valid, mem_req_valid, err_addr, err_source});
    else n_pass++;
    n_total++;
    if ({mem_req_addr, mem_req_data, rsp_data} !== 192'b0 ||
        mem_req_source !== 3'd0 || mem_req_is_read !== 1'b0)
      $display("FAIL reset_fields: got %h/%0d want 0",
               mem_req_addr, mem_req_source);
    else n_pass++;
    req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single_write;
    nxt;
    mem_req_ready = 1'b1;
    set_src(1, 1'b0, 64'h100, D1);
    req_valid = 4'b0010;
    #1;
    n_total++;
    if (req_ready !== 4'b0010)
      $display("FAIL wr_grant: got %b want 0010", req_ready);
    else n_pass++;
    nxt;
    req_valid = '0;
    #1;
    n_total++;
    if (mem_req_valid !== 1'b1 || mem_req_source !== 3'd1 ||
        mem_req_addr !== 64'h100 || mem_req_data !== D1 ||
        mem_req_is_read !== 1'b0 || req_ready !== 4'b0)
      $display("FAIL wr_issue: got v%b s%0d a%h d%h want v1 s1 a100 d%h",
               mem_req_valid, mem_req_source, mem_req_addr,
               mem_req_data, D1);
    else n_pass++;
    nxt;
    #1;
    n_total++;
    if (mem_req_valid !== 1'b0 || rsp_valid !== 4'b0)
      $display("FAIL wr_done: got v%b rsp%b want v0 rsp0000",
               mem_req_valid, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_read_round_trip;
    set_src(2, 1'b1, 64'h100, 64'h0);
    req_valid = 4'b0100;
    #1;
    n_total++;
    if (req_ready !== 4'b0100)
      $display("FAIL rd_grant: got %b want 0100", req_ready);
    else n_pass++;
    nxt;
    req_valid = '0;
    #1;
    n_total++;
    if (mem_req_valid !== 1'b1 || mem_req_is_read !== 1'b1 ||
        mem_req_source !== 3'd2)
      $display("FAIL rd_issue: got v%b r%b s%0d want v1 r1 s2",
               mem_req_valid, mem_req_is_read, mem_req_source);
    else n_pass++;
    nxt;
    repeat (4) begin
      #1;
      n_total++;
      if (rsp_valid !== 4'b0 || mem_req_valid !== 1'b0)
        $display("FAIL rd_wait: got rsp%b v%b want 0",
                 rsp_valid, mem_req_valid);
      else n_pass++;
      nxt;
    end
    mem_rsp_valid  = 1'b1;
    mem_rsp_source = 3'd2;
    mem_rsp_data   = D1;
    nxt;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    #1;
    n_total++;
    if (rsp_valid !== 4'b0100 || rsp_data !== D1)
      $display("FAIL rd_rsp: got %b %h want 0100 %h",
               rsp_valid, rsp_data, D1);
    else n_pass++;
    nxt;
    #1;
    n_total++;
    if (rsp_valid !== 4'b0)
      $display("FAIL rd_pulse: got %b want 0000", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_out_of_range;
    set_src(0, 1'b1, 64'hFFF9, 64'h0);
    req_valid = 4'b0001;
    #1;
    n_total++;
    if (req_ready !== 4'b0001)
      $display("FAIL oor_grant: got %b want 0001", req_ready);
    else n_pass++;
    nxt;
    req_valid = '0;
    #1;
    n_total++;
    if (err_addr !== 1'b1 || rsp_valid !== 4'b0001 ||
        rsp_data !== 64'h0 || mem_req_valid !== 1'b0)
      $display("FAIL oor_read: got e%b rsp%b d%h v%b want e1 0001 0 v0",
               err_addr, rsp_valid, rsp_data, mem_req_valid);
    else n_pass++;
    nxt;
    #1;
    n_total++;
    if (rsp_valid !== 4'b0 || mem_req_valid !== 1'b0)
      $display("FAIL oor_after: got rsp%b v%b want 0",
               rsp_valid, mem_req_valid);
    else n_pass++;
    set_src(1, 1'b0, 64'h10000, 64'hAA);
    req_valid = 4'b0010;
    #1;
    n_total++;
    if (req_ready !== 4'b0010)
      $display("FAIL oorw_grant: got %b want 0010", req_ready);
    else n_pass++;
    nxt;
    req_valid = '0;
    #1;
    n_total++;
    if (mem_req_valid !== 1'b0 || rsp_valid !== 4'b0)
      $display("FAIL oorw_drop: got v%b rsp%b want v0 rsp0",
               mem_req_valid, rsp_valid);
    else n_pass++;
    set_src(2, 1'b0, 64'hFFF8, 64'hBB);
    req_valid = 4'b0100;
    nxt;
    req_valid = '0;
    #1;
    n_total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'hFFF8)
      $display("FAIL edge_addr: got v%b a%h want v1 aFFF8",
               mem_req_valid, mem_req_addr);
    else n_pass++;
    nxt;
  endtask

  task automatic test_fairness;
    reset = 1'b1;
    nxt;
    nxt;
    reset = 1'b0;
    for (int s = 0; s < NS; s++)
      set_src(s, 1'b0, 64'h1000 + 64'(s) * 8, 64'(s));
    req_valid = 4'b1111;
    mem_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_total++;
      if (req_ready !== (4'b0001 << (k % NS)))
        $display("FAIL rr_grant%0d: got %b want %b", k,
                 req_ready, 4'b0001 << (k % NS));
      else n_pass++;
      nxt;
      #1;
      n_total++;
      if (mem_req_source !== 3'(k % NS) || req_ready !== 4'b0)
        $display("FAIL rr_issue%0d: got s%0d r%b want s%0d r0000",
                 k, mem_req_source, req_ready, k % NS);
      else n_pass++;
      nxt;
    end
  endtask

  task automatic test_backpressure;
    mem_req_ready = 1'b0;
    #1;
    n_total++;
    if (req_ready !== 4'b0100)
      $display("FAIL bp_grant: got %b want 0100", req_ready);
    else n_pass++;
    nxt;
    for (int c = 1; c <= 10; c++) begin
      #1;
      n_total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1010 ||
          mem_req_source !== 3'd2 || req_ready !== 4'b0)
        $display("FAIL bp_hold%0d: got v%b a%h s%0d r%b want v1 a1010 s2 r0",
                 c, mem_req_valid, mem_req_addr, mem_req_source,
                 req_ready);
      else n_pass++;
      nxt;
    end
    mem_req_ready = 1'b1;
    #1;
    n_total++;
    if (mem_req_valid !== 1'b1)
      $display("FAIL bp_c11: got %b want 1", mem_req_valid);
    else n_pass++;
    nxt;
    #1;
    n_total++;
    if (mem_req_valid !== 1'b0 || req_ready !== 4'b1000)
      $display("FAIL bp_accept: got v%b r%b want v0 r1000",
               mem_req_valid, req_ready);
    else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_bad_tag_reset;
    set_src(3, 1'b1, 64'h200, 64'h0);
    req_valid = 4'b1000;
    #1;
    n_total++;
    if (req_ready !== 4'b1000)
      $display("FAIL bt_grant: got %b want 1000", req_ready);
    else n_pass++;
    nxt;
    req_valid = '0;
    nxt;
    #1;
    n_total++;
    if (err_source !== 1'b0)
      $display("FAIL bt_pre: got %b want 0", err_source);
    else n_pass++;
    mem_rsp_valid  = 1'b1;
    mem_rsp_source = 3'd0;
    mem_rsp_data   = 64'hDEAD;
    nxt;
    mem_rsp_valid = 1'b0;
    #1;
    n_total++;
    if (err_source !== 1'b1 || rsp_valid !== 4'b0)
      $display("FAIL bt_err: got e%b rsp%b want e1 rsp0",
               err_source, rsp_valid);
    else n_pass++;
    req_valid = 4'b0001;
    #1;
    n_total++;
    if (req_ready !== 4'b0 || mem_req_valid !== 1'b0)
      $display("FAIL bt_wait: got r%b v%b want r0 v0",
               req_ready, mem_req_valid);
    else n_pass++;
    reset = 1'b1;
    nxt;
    #1;
    n_total++;
    if ({rsp_valid, req_ready, mem_req_valid, err_addr,
         err_source} !== 11'b0 || mem_req_addr !== 64'h0 ||
        mem_req_source !== 3'd0)
      $display("FAIL bt_reset: got e%b v%b a%h want 0",
               err_source, mem_req_valid, mem_req_addr);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (req_ready !== 4'b0001)
      $display("FAIL bt_idle: got %b want 0001", req_ready);
    else n_pass++;
    req_valid = '0;
    nxt;
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    reset          = 1'b1;
    req_valid      = '0;
    req_is_read    = '0;
    req_addr       = '0;
    req_data       = '0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    mem_rsp_source = '0;
    test_reset;
    test_single_write;
    test_read_round_trip;
    test_out_of_range;
    test_fairness;
    test_backpressure;
    test_bad_tag_reset;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
